// File: rtl/cpu_pkg.sv
// Shared definitions for the 2-stage 4-bit CPU: widths, opcodes and jump-class helpers.
// Both the fetch stage and the execute-stage decoder import JUMP_CLASS from here.
package cpu_pkg;

    localparam int PC_W     = 4;
    localparam int INSTR_W  = 8;
    localparam int OPCODE_W = 4;
    localparam int IMM_W    = 4;

    typedef logic [PC_W-1:0]    pc_t;
    typedef logic [INSTR_W-1:0] instr_t;

    typedef struct packed {
        logic [OPCODE_W-1:0] opcode;
        logic [IMM_W-1:0]    imm;
    } instr_fields_t;

    localparam logic [OPCODE_W-1:0] OP_JNC      = 4'b1110;
    localparam logic [OPCODE_W-1:0] OP_JMP      = 4'b1111;
    localparam logic [2:0]          JUMP_CLASS  = 3'b111;
    localparam instr_t              RESET_INSTR = 8'h00;
    localparam pc_t                 PC_ONE      = pc_t'(1);
    localparam pc_t                 PC_MAX      = '1;

    typedef enum logic [1:0] {
        PC_SEQ,
        PC_TAKEN,
        PC_REFETCH
    } pc_sel_e;

    function automatic logic is_jump_class(input instr_t ir);
        return ir[INSTR_W-1 -: 3] == JUMP_CLASS;
    endfunction

    // JMP always redirects; JNC redirects only while the carry flag is clear.
    function automatic logic jump_taken(input instr_t ir, input logic carry);
        instr_fields_t f;
        f = ir;
        return (f.opcode == OP_JMP) || ((f.opcode == OP_JNC) && !carry);
    endfunction

    function automatic pc_t imm_to_pc(input instr_t ir);
        instr_fields_t            f;
        logic [PC_W+IMM_W-1:0]    wide;
        f    = ir;
        wide = {{PC_W{1'b0}}, f.imm};
        return wide[PC_W-1:0];
    endfunction

endpackage

// File: rtl/fetch_stage_pc_next.sv
// Combinational next-PC selection for the fetch stage.
// With FETCH_WRAP_FLAG_EN defined it also reports a sequential 2^PC_W-1 -> 0 step.
module pc_next_logic
    import cpu_pkg::*;
(
    input  logic [PC_W-1:0]    pc,
    input  logic [PC_W-1:0]    ir_pc,
    input  logic [INSTR_W-1:0] ir,
    input  logic               carry,
    input  logic               squash,
    output logic [PC_W-1:0]    pc_next
`ifdef FETCH_WRAP_FLAG_EN
    ,
    output logic               seq_wrap
`endif
);

    pc_sel_e sel;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        sel = PC_SEQ;
        if (!squash && is_jump_class(ir)) begin
            sel = jump_taken(ir, carry) ? PC_TAKEN : PC_REFETCH;
        end
    end

    // A not-taken jump refetches the word the execute stage is about to squash.
    always_comb begin
        pc_next = pc + PC_ONE;
        case (sel)
            PC_TAKEN:   pc_next = imm_to_pc(ir);
            PC_REFETCH: pc_next = ir_pc + PC_ONE;
            default:    pc_next = pc + PC_ONE;
        endcase
    end

`ifdef FETCH_WRAP_FLAG_EN
    assign seq_wrap = (sel == PC_SEQ) && (pc == PC_MAX);
`endif

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC, instruction-ROM addressing, IR and jump redirect with wrong-path tracking.
// Optional sticky pc_wrap output is enabled by defining FETCH_WRAP_FLAG_EN.
module fetch_stage
    import cpu_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               carry,
    output logic [INSTR_W-1:0] D_BUS,
    output logic [PC_W-1:0]    ir_pc
`ifdef FETCH_WRAP_FLAG_EN
    ,
    output logic               pc_wrap
`endif
);

    pc_t    pc_q;
    pc_t    ir_pc_q;
    instr_t ir_q;
    logic   squash_q;
    pc_t    pc_next;

`ifdef FETCH_WRAP_FLAG_EN
    logic   seq_wrap;
    logic   wrap_q;
`endif

    pc_next_logic u_pc_next (
        .pc       (pc_q),
        .ir_pc    (ir_pc_q),
        .ir       (ir_q),
        .carry    (carry),
        .squash   (squash_q),
        .pc_next  (pc_next)
`ifdef FETCH_WRAP_FLAG_EN
        ,
        .seq_wrap (seq_wrap)
`endif
    );

    // squash mirrors the decoder: a jump landing in the wrong-path slot must not redirect.
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q     <= '0;
            ir_q     <= RESET_INSTR;
            ir_pc_q  <= '0;
            squash_q <= 1'b0;
        end else begin
            pc_q     <= pc_next;
            ir_q     <= imem_data;
            ir_pc_q  <= pc_q;
            squash_q <= ~squash_q & is_jump_class(ir_q);
        end
    end

`ifdef FETCH_WRAP_FLAG_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            wrap_q <= 1'b0;
        end else if (seq_wrap) begin
            wrap_q <= 1'b1;
        end
    end

    assign pc_wrap = wrap_q;
`endif

    assign imem_addr = pc_q;
    assign D_BUS     = ir_q;
    assign ir_pc     = ir_pc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed program scenarios plus random ROM/carry
// traffic compared against a program-order reference model.
module tb_fetch_stage;

    logic       clock;
    logic       reset;
    logic [3:0] imem_addr;
    logic [7:0] imem_data;
    logic       carry;
    logic [7:0] D_BUS;
    logic [3:0] ir_pc;
`ifdef FETCH_WRAP_FLAG_EN
    logic       pc_wrap;
`endif

    logic [7:0] rom [16];

    int checks = 0;
    int passed = 0;
    int failed = 0;

    // Reference model: the fetch address, the instruction word held for execute,
    // where it came from, and whether that word is the wrong-path slot after a jump.
    int         m_pc;
    logic [7:0] m_ir;
    int         m_irpc;
    bit         m_wrong;
    bit         m_wrap;

    fetch_stage dut (
        .clock     (clock),
        .reset     (reset),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .carry     (carry),
        .D_BUS     (D_BUS),
        .ir_pc     (ir_pc)
`ifdef FETCH_WRAP_FLAG_EN
        ,
        .pc_wrap   (pc_wrap)
`endif
    );

    assign imem_data = rom[imem_addr];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic [7:0] fetched;
        bit         is_jump;
        int         npc;
        if (reset) begin
            m_pc = 0; m_ir = 8'h00; m_irpc = 0; m_wrong = 0; m_wrap = 0;
        end else begin
            fetched = rom[m_pc];
            is_jump = (m_ir[7:5] == 3'b111);
            if (is_jump && !m_wrong) begin
                if (m_ir[7:4] == 4'hF || carry == 1'b0) npc = int'(m_ir[3:0]);
                else                                     npc = (m_irpc + 1) % 16;
            end else begin
                npc = (m_pc + 1) % 16;
                if (m_pc == 15) m_wrap = 1;
            end
            m_wrong = is_jump && !m_wrong;
            m_irpc  = m_pc;
            m_ir    = fetched;
            m_pc    = npc;
        end
    endtask

    task automatic step(input logic rst, input logic cy);
        @(negedge clock);
        reset = rst;
        carry = cy;
        @(posedge clock);
        model_edge();
        #1;
        check("model_pc",    {4'h0, imem_addr}, 8'(m_pc));
        check("model_dbus",  D_BUS,             m_ir);
        check("model_ir_pc", {4'h0, ir_pc},     8'(m_irpc));
`ifdef FETCH_WRAP_FLAG_EN
        check("model_wrap",  {7'h0, pc_wrap},   {7'h0, m_wrap});
`endif
    endtask

    task automatic lit(input string tag, input int pc, input logic [7:0] d, input int irpc);
        check({tag, "_pc"},    {4'h0, imem_addr}, 8'(pc));
        check({tag, "_dbus"},  D_BUS,             d);
        check({tag, "_ir_pc"}, {4'h0, ir_pc},     8'(irpc));
    endtask

    task automatic load_seq_rom();
        for (int i = 0; i < 16; i++) rom[i] = 8'(i);
    endtask

    task automatic run(input int n, input logic cy);
        for (int i = 0; i < n; i++) step(1'b0, cy);
    endtask

    initial begin
        reset = 1'b1;
        carry = 1'b0;
        load_seq_rom();

        // Reset state and sequential fetch
        step(1'b1, 1'b0); lit("rst", 0, 8'h00, 0);
        step(1'b0, 1'b0); lit("seq1", 1, 8'h00, 0);
        step(1'b0, 1'b0); lit("seq2", 2, 8'h01, 1);
        step(1'b0, 1'b0); lit("seq3", 3, 8'h02, 2);

        // JMP at 3 to 9; word 4 is fetched on the wrong path
        load_seq_rom(); rom[3] = 8'hF9;
        step(1'b1, 1'b0); run(3, 1'b0);
        step(1'b0, 1'b0); lit("jmp_ir", 4, 8'hF9, 3);
        step(1'b0, 1'b0); lit("jmp_redir", 9, 8'h04, 4);
        step(1'b0, 1'b0); lit("jmp_target", 10, 8'h09, 9);

        // Reset while the jump sits in IR overrides the redirect
        step(1'b1, 1'b0); run(3, 1'b0);
        step(1'b0, 1'b0); lit("rstjmp_ir", 4, 8'hF9, 3);
        step(1'b1, 1'b0); lit("rstjmp_rst", 0, 8'h00, 0);
        step(1'b0, 1'b0); lit("rstjmp_1", 1, 8'h00, 0);
        step(1'b0, 1'b0); lit("rstjmp_2", 2, 8'h01, 1);

        // JNC taken (carry clear)
        load_seq_rom(); rom[2] = 8'hE7;
        step(1'b1, 1'b0); run(2, 1'b0);
        step(1'b0, 1'b0); lit("jnc0_ir", 3, 8'hE7, 2);
        step(1'b0, 1'b0); lit("jnc0_redir", 7, 8'h03, 3);
        step(1'b0, 1'b0); lit("jnc0_target", 8, 8'h07, 7);

        // JNC not taken (carry set): squashed word 3 is refetched
        step(1'b1, 1'b1); run(2, 1'b1);
        step(1'b0, 1'b1); lit("jnc1_ir", 3, 8'hE7, 2);
        step(1'b0, 1'b1); lit("jnc1_refetch", 3, 8'h03, 3);
        step(1'b0, 1'b1); lit("jnc1_again", 4, 8'h03, 3);
        step(1'b0, 1'b1); lit("jnc1_next", 5, 8'h04, 4);

        // Back-to-back jumps: the second one is wrong-path and never redirects
        load_seq_rom(); rom[5] = 8'hF0; rom[6] = 8'hFC;
        step(1'b1, 1'b0); run(5, 1'b0);
        step(1'b0, 1'b0); lit("b2b_ir", 6, 8'hF0, 5);
        step(1'b0, 1'b0); lit("b2b_redir", 0, 8'hFC, 6);
        step(1'b0, 1'b0); lit("b2b_nored", 1, 8'h00, 0);
        step(1'b0, 1'b0); lit("b2b_seq", 2, 8'h01, 1);

        // Jump to self loops with period 2
        load_seq_rom(); rom[4] = 8'hF4;
        step(1'b1, 1'b0); run(4, 1'b0);
        step(1'b0, 1'b0); lit("self_a0", 5, 8'hF4, 4);
        step(1'b0, 1'b0); lit("self_b0", 4, 8'h05, 5);
        step(1'b0, 1'b0); lit("self_a1", 5, 8'hF4, 4);
        step(1'b0, 1'b0); lit("self_b1", 4, 8'h05, 5);

`ifdef FETCH_WRAP_FLAG_EN
        // Sequential wrap sets the sticky flag; a jump from 15 to 0 does not
        load_seq_rom();
        step(1'b1, 1'b0); check("wrap_rst", {7'h0, pc_wrap}, 8'h00);
        run(15, 1'b0);    check("wrap_pre", {7'h0, pc_wrap}, 8'h00);
        lit("wrap_at15", 15, 8'h0E, 14);
        step(1'b0, 1'b0); check("wrap_set", {7'h0, pc_wrap}, 8'h01);
        lit("wrap_to0", 0, 8'h0F, 15);
        run(3, 1'b0);     check("wrap_hold", {7'h0, pc_wrap}, 8'h01);
        rom[14] = 8'hF0;
        step(1'b1, 1'b0); check("wrap_clr", {7'h0, pc_wrap}, 8'h00);
        run(14, 1'b0);
        step(1'b0, 1'b0); lit("wjmp_ir", 15, 8'hF0, 14);
        step(1'b0, 1'b0); check("wjmp_nowrap", {7'h0, pc_wrap}, 8'h00);
        lit("wjmp_redir", 0, 8'h0F, 15);
        step(1'b0, 1'b0); check("wjmp_nowrap2", {7'h0, pc_wrap}, 8'h00);
`endif

        // Random programs with jump-heavy ROMs, random carry and occasional reset
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 16; i++) begin
                logic [7:0] w;
                w = 8'($urandom);
                if ($urandom_range(0, 99) < 40) w[7:5] = 3'b111;
                else if (w[7:5] == 3'b111)       w[7] = 1'b0;
                rom[i] = w;
            end
            step(1'b1, 1'b0);
            for (int c = 0; c < 250; c++) begin
                step(($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0, 1'($urandom_range(0, 1)));
            end
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
